// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory port, IF/ID outputs and control.
// FETCH_INTR_EN adds the interrupt request/acknowledge signals.
interface fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] imem_read_data;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic        imem_cs;
  logic        imem_write;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
`ifdef FETCH_INTR_EN
  logic        intr;
  logic [31:0] intr_vec;
  logic [31:0] epc;
  logic        intr_ack;

  modport master (
    input  stall, redirect, redirect_pc, imem_read_data,
    input  intr, intr_vec,
    output imem_addr, imem_read, imem_cs, imem_write,
    output if_id_inst, if_id_imm, if_id_pc, if_id_valid,
    output epc, intr_ack
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_read_data,
    output intr, intr_vec,
    input  imem_addr, imem_read, imem_cs, imem_write,
    input  if_id_inst, if_id_imm, if_id_pc, if_id_valid,
    input  epc, intr_ack
  );
`else
  modport master (
    input  stall, redirect, redirect_pc, imem_read_data,
    output imem_addr, imem_read, imem_cs, imem_write,
    output if_id_inst, if_id_imm, if_id_pc, if_id_valid
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_read_data,
    input  imem_addr, imem_read, imem_cs, imem_write,
    input  if_id_inst, if_id_imm, if_id_pc, if_id_valid
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one/two-word assembly, IF/ID register.
// Optional interrupt entry is enabled with FETCH_INTR_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd32,
  parameter logic [4:0]  IMM_OPCODE = 5'b00001,
  parameter logic [15:0] NOP_WORD   = 16'h2800
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic {FETCH_OP, FETCH_IMM} state_t;

  state_t      r_state, w_state;
  logic [19:0] r_pc, w_pc, w_pc_inc;
  logic [15:0] r_hold_inst, w_hold_inst;
  logic [19:0] r_hold_pc, w_hold_pc;
  logic [15:0] r_inst, w_inst;
  logic [15:0] r_imm, w_imm;
  logic [19:0] r_if_pc, w_if_pc;
  logic        r_valid, w_valid;
  logic        w_unused;

  // Only the low 20 address bits exist; upper bits always read as 0.
  assign w_pc_inc = r_pc + 20'd1;

`ifdef FETCH_INTR_EN
  logic [19:0] r_epc, w_epc;
  logic        r_ack, w_ack;

  assign w_unused     = &{1'b0, bus.redirect_pc[31:20],
                          bus.intr_vec[31:20]};
  assign bus.epc      = {12'd0, r_epc};
  assign bus.intr_ack = r_ack;
`else
  assign w_unused = &{1'b0, bus.redirect_pc[31:20]};
`endif

  assign bus.imem_addr   = {12'd0, r_pc};
  assign bus.imem_read   = ~rst;
  assign bus.imem_cs     = ~rst;
  assign bus.imem_write  = 1'b0;
  assign bus.if_id_inst  = r_inst;
  assign bus.if_id_imm   = r_imm;
  assign bus.if_id_pc    = {12'd0, r_if_pc};
  assign bus.if_id_valid = r_valid;

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_hold_inst = r_hold_inst;
    w_hold_pc   = r_hold_pc;
    w_inst      = r_inst;
    w_imm       = r_imm;
    w_if_pc     = r_if_pc;
    w_valid     = r_valid;
`ifdef FETCH_INTR_EN
    w_epc       = r_epc;
    w_ack       = 1'b0;
`endif
    if (bus.redirect) begin
      w_pc        = bus.redirect_pc[19:0];
      w_state     = FETCH_OP;
      w_hold_inst = 16'd0;
      w_inst      = NOP_WORD;
      w_imm       = 16'd0;
      w_valid     = 1'b0;
    end else if (!bus.stall) begin
      unique case (r_state)
        FETCH_OP: begin
`ifdef FETCH_INTR_EN
          // Current word is dropped; epc makes it refetch on return.
          if (bus.intr && !r_ack) begin
            w_epc   = r_pc;
            w_pc    = bus.intr_vec[19:0];
            w_inst  = NOP_WORD;
            w_imm   = 16'd0;
            w_valid = 1'b0;
            w_ack   = 1'b1;
          end else
`endif
          if (bus.imem_read_data[15:11] == IMM_OPCODE) begin
            w_hold_inst = bus.imem_read_data;
            w_hold_pc   = r_pc;
            w_pc        = w_pc_inc;
            w_state     = FETCH_IMM;
            w_inst      = NOP_WORD;
            w_imm       = 16'd0;
            w_valid     = 1'b0;
          end else begin
            w_inst  = bus.imem_read_data;
            w_imm   = 16'd0;
            w_if_pc = r_pc;
            w_valid = 1'b1;
            w_pc    = w_pc_inc;
          end
        end
        FETCH_IMM: begin
          w_inst  = r_hold_inst;
          w_imm   = bus.imem_read_data;
          w_if_pc = r_hold_pc;
          w_valid = 1'b1;
          w_pc    = w_pc_inc;
          w_state = FETCH_OP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH_OP;
      r_pc        <= RESET_PC[19:0];
      r_hold_inst <= 16'd0;
      r_hold_pc   <= 20'd0;
      r_inst      <= NOP_WORD;
      r_imm       <= 16'd0;
      r_if_pc     <= 20'd0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_hold_inst <= w_hold_inst;
      r_hold_pc   <= w_hold_pc;
      r_inst      <= w_inst;
      r_imm       <= w_imm;
      r_if_pc     <= w_if_pc;
      r_valid     <= w_valid;
    end
  end

`ifdef FETCH_INTR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epc <= 20'd0;
      r_ack <= 1'b0;
    end else begin
      r_epc <= w_epc;
      r_ack <= w_ack;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  bit [15:0] mem [0:1048575];

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.imem_read_data = mem[bus.imem_addr[19:0]];
`ifdef FETCH_INTR_EN
  initial begin
    bus.intr     = 1'b0;
    bus.intr_vec = 32'd0;
  end
`endif

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    #1;
    n_chk++; if (bus.imem_read !== 1'b0) begin n_fail++; $display("FAIL rst_read got %b want 0", bus.imem_read); end
    n_chk++; if (bus.imem_cs !== 1'b0) begin n_fail++; $display("FAIL rst_cs got %b want 0", bus.imem_cs); end
    n_chk++; if (bus.imem_write !== 1'b0) begin n_fail++; $display("FAIL rst_write got %b want 0", bus.imem_write); end
    n_chk++; if (bus.imem_addr !== 32'd32) begin n_fail++; $display("FAIL rst_addr got %h want %h", bus.imem_addr, 32'd32); end
    n_chk++; if (bus.if_id_inst !== 16'h2800) begin n_fail++; $display("FAIL rst_inst got %h want 2800", bus.if_id_inst); end
    n_chk++; if (bus.if_id_imm !== 16'h0000) begin n_fail++; $display("FAIL rst_imm got %h want 0000", bus.if_id_imm); end
    n_chk++; if (bus.if_id_pc !== 32'd0) begin n_fail++; $display("FAIL rst_pc got %h want 0", bus.if_id_pc); end
    n_chk++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.if_id_valid); end
    step();
    rst = 1'b0;
    #1;
    n_chk++; if (bus.imem_read !== 1'b1) begin n_fail++; $display("FAIL rel_read got %b want 1", bus.imem_read); end
    n_chk++; if (bus.imem_cs !== 1'b1) begin n_fail++; $display("FAIL rel_cs got %b want 1", bus.imem_cs); end
  endtask

  task automatic test_one_word();
    mem[32] = 16'h1A20;
    mem[33] = 16'h2120;
    mem[34] = 16'h1234;
    do_reset();
    n_chk++; if (bus.imem_addr !== 32'd32) begin n_fail++; $display("FAIL ow_addr0 got %h want 20", bus.imem_addr); end
    step();
    n_chk++; if (bus.if_id_inst !== 16'h1A20) begin n_fail++; $display("FAIL ow_inst0 got %h want 1A20", bus.if_id_inst); end
    n_chk++; if (bus.if_id_pc !== 32'd32) begin n_fail++; $display("FAIL ow_pc0 got %h want 20", bus.if_id_pc); end
    n_chk++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ow_valid0 got %b want 1", bus.if_id_valid); end
    n_chk++; if (bus.imem_addr !== 32'd33) begin n_fail++; $display("FAIL ow_addr1 got %h want 21", bus.imem_addr); end
    step();
    n_chk++; if (bus.if_id_inst !== 16'h2120) begin n_fail++; $display("FAIL ow_inst1 got %h want 2120", bus.if_id_inst); end
    n_chk++; if (bus.if_id_pc !== 32'd33) begin n_fail++; $display("FAIL ow_pc1 got %h want 21", bus.if_id_pc); end
    n_chk++; if (bus.if_id_imm !== 16'h0000) begin n_fail++; $display("FAIL ow_imm1 got %h want 0000", bus.if_id_imm); end
    n_chk++; if (bus.imem_addr !== 32'd34) begin n_fail++; $display("FAIL ow_addr2 got %h want 22", bus.imem_addr); end
  endtask

  task automatic test_ldm();
    mem[32] = 16'h0820;
    mem[33] = 16'h0002;
    mem[34] = 16'h1A20;
    do_reset();
    step();
    n_chk++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL ldm_bub_valid got %b want 0", bus.if_id_valid); end
    n_chk++; if (bus.if_id_inst !== 16'h2800) begin n_fail++; $display("FAIL ldm_bub_inst got %h want 2800", bus.if_id_inst); end
    n_chk++; if (bus.imem_addr !== 32'd33) begin n_fail++; $display("FAIL ldm_addr1 got %h want 21", bus.imem_addr); end
    step();
    n_chk++; if (bus.if_id_inst !== 16'h0820) begin n_fail++; $display("FAIL ldm_inst got %h want 0820", bus.if_id_inst); end
    n_chk++; if (bus.if_id_imm !== 16'h0002) begin n_fail++; $display("FAIL ldm_imm got %h want 0002", bus.if_id_imm); end
    n_chk++; if (bus.if_id_pc !== 32'd32) begin n_fail++; $display("FAIL ldm_pc got %h want 20", bus.if_id_pc); end
    n_chk++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ldm_valid got %b want 1", bus.if_id_valid); end
    n_chk++; if (bus.imem_addr !== 32'd34) begin n_fail++; $display("FAIL ldm_addr2 got %h want 22", bus.imem_addr); end
    step();
    n_chk++; if (bus.if_id_inst !== 16'h1A20) begin n_fail++; $display("FAIL ldm_next_inst got %h want 1A20", bus.if_id_inst); end
    n_chk++; if (bus.if_id_imm !== 16'h0000) begin n_fail++; $display("FAIL ldm_next_imm got %h want 0000", bus.if_id_imm); end
    n_chk++; if (bus.if_id_pc !== 32'd34) begin n_fail++; $display("FAIL ldm_next_pc got %h want 22", bus.if_id_pc); end
  endtask

  task automatic test_stall();
    mem[32] = 16'h1A20;
    mem[33] = 16'h0820;
    mem[34] = 16'h0005;
    mem[35] = 16'h2120;
    do_reset();
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (bus.if_id_inst !== 16'h1A20 || bus.if_id_pc !== 32'd32 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st_op%0d got %h/%h/%b want 1A20/20/1", i, bus.if_id_inst, bus.if_id_pc, bus.if_id_valid); end
      n_chk++; if (bus.imem_addr !== 32'd33) begin n_fail++; $display("FAIL st_op_addr%0d got %h want 21", i, bus.imem_addr); end
    end
    bus.stall = 1'b0;
    step();
    n_chk++; if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'd34) begin n_fail++; $display("FAIL st_bub got %b/%h want 0/22", bus.if_id_valid, bus.imem_addr); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 16'h2800) begin n_fail++; $display("FAIL st_imm%0d got %b/%h want 0/2800", i, bus.if_id_valid, bus.if_id_inst); end
      n_chk++; if (bus.imem_addr !== 32'd34) begin n_fail++; $display("FAIL st_imm_addr%0d got %h want 22", i, bus.imem_addr); end
    end
    bus.stall = 1'b0;
    step();
    n_chk++; if (bus.if_id_inst !== 16'h0820 || bus.if_id_imm !== 16'h0005) begin n_fail++; $display("FAIL st_pair got %h/%h want 0820/0005", bus.if_id_inst, bus.if_id_imm); end
    n_chk++; if (bus.if_id_pc !== 32'd33 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL st_pair_pc got %h/%b want 21/1", bus.if_id_pc, bus.if_id_valid); end
    step();
    n_chk++; if (bus.if_id_inst !== 16'h2120 || bus.if_id_pc !== 32'd35) begin n_fail++; $display("FAIL st_after got %h/%h want 2120/23", bus.if_id_inst, bus.if_id_pc); end
  endtask

  task automatic test_redirect_imm();
    mem[32] = 16'h0820;
    mem[33] = 16'h0002;
    mem[64] = 16'h2120;
    mem[65] = 16'h0000;
    do_reset();
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    bus.stall = 1'b1;
    step();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    n_chk++; if (bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL rd_addr got %h want 40", bus.imem_addr); end
    n_chk++; if (bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 16'h2800 || bus.if_id_imm !== 16'h0000) begin n_fail++; $display("FAIL rd_flush got %b/%h/%h want 0/2800/0000", bus.if_id_valid, bus.if_id_inst, bus.if_id_imm); end
    step();
    n_chk++; if (bus.if_id_inst !== 16'h2120 || bus.if_id_imm !== 16'h0000) begin n_fail++; $display("FAIL rd_tgt got %h/%h want 2120/0000", bus.if_id_inst, bus.if_id_imm); end
    n_chk++; if (bus.if_id_pc !== 32'h40 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rd_tgt_pc got %h/%b want 40/1", bus.if_id_pc, bus.if_id_valid); end
  endtask

  task automatic test_wrap();
    mem[20'hFFFFF] = 16'h1A20;
    mem[0] = 16'h2120;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hABCF_FFFF;
    step();
    bus.redirect = 1'b0;
    n_chk++; if (bus.imem_addr !== 32'h000F_FFFF) begin n_fail++; $display("FAIL wr_addr got %h want 000FFFFF", bus.imem_addr); end
    step();
    n_chk++; if (bus.if_id_pc !== 32'h000F_FFFF || bus.if_id_inst !== 16'h1A20) begin n_fail++; $display("FAIL wr_pc got %h/%h want 000FFFFF/1A20", bus.if_id_pc, bus.if_id_inst); end
    n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_next got %h want 0", bus.imem_addr); end
    step();
    n_chk++; if (bus.if_id_pc !== 32'h0 || bus.if_id_inst !== 16'h2120) begin n_fail++; $display("FAIL wr_zero got %h/%h want 0/2120", bus.if_id_pc, bus.if_id_inst); end
    mem[20'hFFFFF] = 16'h0820;
    mem[0] = 16'h0003;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h000F_FFFF;
    step();
    bus.redirect = 1'b0;
    step();
    n_chk++; if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wl_bub got %b/%h want 0/0", bus.if_id_valid, bus.imem_addr); end
    step();
    n_chk++; if (bus.if_id_inst !== 16'h0820 || bus.if_id_imm !== 16'h0003 || bus.if_id_pc !== 32'h000F_FFFF) begin n_fail++; $display("FAIL wl_pair got %h/%h/%h want 0820/0003/000FFFFF", bus.if_id_inst, bus.if_id_imm, bus.if_id_pc); end
  endtask

  task automatic test_async_reset();
    mem[32] = 16'h1A20;
    mem[33] = 16'h0820;
    mem[34] = 16'h0002;
    do_reset();
    step();
    step();
    n_chk++; if (bus.imem_addr !== 32'd34 || bus.if_id_pc !== 32'd32) begin n_fail++; $display("FAIL ar_pre got %h/%h want 22/20", bus.imem_addr, bus.if_id_pc); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.imem_addr !== 32'd32) begin n_fail++; $display("FAIL ar_addr got %h want 20", bus.imem_addr); end
    n_chk++; if (bus.if_id_valid !== 1'b0 || bus.if_id_inst !== 16'h2800 || bus.if_id_pc !== 32'd0) begin n_fail++; $display("FAIL ar_ifid got %b/%h/%h want 0/2800/0", bus.if_id_valid, bus.if_id_inst, bus.if_id_pc); end
    n_chk++; if (bus.imem_read !== 1'b0 || bus.imem_cs !== 1'b0) begin n_fail++; $display("FAIL ar_strobe got %b/%b want 0/0", bus.imem_read, bus.imem_cs); end
    #2;
    rst = 1'b0;
    step();
    n_chk++; if (bus.if_id_inst !== 16'h1A20 || bus.if_id_pc !== 32'd32 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL ar_restart got %h/%h/%b want 1A20/20/1", bus.if_id_inst, bus.if_id_pc, bus.if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_ldm();
    test_stall();
    test_redirect_imm();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
